// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, redirect flushes,
// memory-wait freeze, with saturating stall/flush performance counters.
module pipeline_hazard_controller #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs_i,
  input  logic [4:0]           id_rt_i,
  input  logic                 id_uses_rt_i,
  input  logic                 ex_mem_read_i,
  input  logic [4:0]           ex_rt_i,
  input  logic                 redirect_i,
  input  logic                 mem_busy_i,
  output logic                 pc_disenable_o,
  output logic                 ifid_disenable_o,
  output logic                 idex_disenable_o,
  output logic                 exmem_disenable_o,
  output logic                 ifid_flush_o,
  output logic                 idex_flush_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic [CNT_WIDTH-1:0] flush_count_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] LOAD_RELOAD  = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       flush_inc;
  logic       load_use;

  logic [CNT_WIDTH-1:0] stall_cycles_reg, flush_count_reg;

  assign load_use = ex_mem_read_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  always_comb begin
    pc_disenable_o    = 1'b0;
    ifid_disenable_o  = 1'b0;
    idex_disenable_o  = 1'b0;
    exmem_disenable_o = 1'b0;
    ifid_flush_o      = 1'b0;
    idex_flush_o      = 1'b0;
    flush_inc         = 1'b0;
    state_next        = state_reg;
    cnt_next          = cnt_reg;

    if (reset) begin
      state_next = RUN;
      cnt_next   = 4'd0;
    end else if (mem_busy_i) begin
      // Freeze: every stage holds and the sequencer itself holds too.
      pc_disenable_o    = 1'b1;
      ifid_disenable_o  = 1'b1;
      idex_disenable_o  = 1'b1;
      exmem_disenable_o = 1'b1;
    end else if (redirect_i) begin
      ifid_flush_o = 1'b1;
      flush_inc    = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_next = FLUSH;
        cnt_next   = FLUSH_RELOAD;
      end else begin
        state_next = RUN;
        cnt_next   = 4'd0;
      end
    end else begin
      case (state_reg)
        RUN: begin
          if (load_use) begin
            pc_disenable_o   = 1'b1;
            ifid_disenable_o = 1'b1;
            idex_flush_o     = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_next = STALL;
              cnt_next   = LOAD_RELOAD;
            end
          end
        end
        STALL: begin
          pc_disenable_o   = 1'b1;
          ifid_disenable_o = 1'b1;
          idex_flush_o     = 1'b1;
          cnt_next         = cnt_reg - 4'd1;
          if (cnt_reg <= 4'd1) state_next = RUN;
        end
        FLUSH: begin
          ifid_flush_o = 1'b1;
          cnt_next     = cnt_reg - 4'd1;
          if (cnt_reg <= 4'd1) state_next = RUN;
        end
        default: begin
          state_next = RUN;
          cnt_next   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= RUN;
      cnt_reg          <= 4'd0;
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (pc_disenable_o && (stall_cycles_reg != CNT_MAX))
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
      if (flush_inc && (flush_count_reg != CNT_MAX))
        flush_count_reg <= flush_count_reg + 1'b1;
    end
  end

  assign stall_cycles_o = stall_cycles_reg;
  assign flush_count_o  = flush_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: driver computes expected per-cycle response from a bubble/flush
// budget model; a negedge monitor pops and compares.
module tb_pipeline_hazard_controller;

  localparam int L  = 2;
  localparam int F  = 3;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, id_uses_rt_i, ex_mem_read_i, redirect_i, mem_busy_i;
  logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
  logic pc_disenable_o, ifid_disenable_o, idex_disenable_o, exmem_disenable_o;
  logic ifid_flush_o, idex_flush_o;
  logic [CW-1:0] stall_cycles_o, flush_count_o;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .LOAD_STALL_CYCLES(L), .FLUSH_CYCLES(F), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_rt_i(ex_rt_i),
    .redirect_i(redirect_i), .mem_busy_i(mem_busy_i),
    .pc_disenable_o(pc_disenable_o), .ifid_disenable_o(ifid_disenable_o),
    .idex_disenable_o(idex_disenable_o), .exmem_disenable_o(exmem_disenable_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o),
    .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
  );

  typedef struct packed {
    logic [5:0]    ctl;  // {pc_dis, ifid_dis, idex_dis, exmem_dis, ifid_flush, idex_flush}
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int txn = 0;

  // Reference model: remaining forced bubbles / flushes and event tallies.
  int stall_left = 0;
  int flush_left = 0;
  int m_sc = 0;
  int m_fc = 0;

  task automatic cyc(input logic rst, input logic busy, input logic redir,
                     input logic rd, input logic [4:0] ert, input logic [4:0] rs,
                     input logic [4:0] rt, input logic urt);
    exp_t e;
    logic lu;
    @(posedge clk);
    #1;
    reset = rst; mem_busy_i = busy; redirect_i = redir; ex_mem_read_i = rd;
    ex_rt_i = ert; id_rs_i = rs; id_rt_i = rt; id_uses_rt_i = urt;
    lu = rd && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
    e.sc  = CW'(m_sc);
    e.fc  = CW'(m_fc);
    e.ctl = 6'b000000;
    if (rst) begin
      stall_left = 0; flush_left = 0; m_sc = 0; m_fc = 0;
    end else if (busy) begin
      e.ctl = 6'b111100;
      if (m_sc < CMAX) m_sc++;
    end else if (redir) begin
      e.ctl = 6'b000010;
      if (m_fc < CMAX) m_fc++;
      flush_left = F - 1;
      stall_left = 0;
    end else if (flush_left > 0) begin
      e.ctl = 6'b000010;
      flush_left--;
    end else if (stall_left > 0) begin
      e.ctl = 6'b110001;
      stall_left--;
      if (m_sc < CMAX) m_sc++;
    end else if (lu) begin
      e.ctl = 6'b110001;
      stall_left = L - 1;
      if (m_sc < CMAX) m_sc++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {pc_disenable_o, ifid_disenable_o, idex_disenable_o,
               exmem_disenable_o, ifid_flush_o, idex_flush_o};
        txn++;
        checks++;
        if (act !== e.ctl) begin
          errors++;
          $display("FAIL ctl txn=%0d got=%b want=%b", txn, act, e.ctl);
        end
        checks++;
        if ((stall_cycles_o !== e.sc) || (flush_count_o !== e.fc)) begin
          errors++;
          $display("FAIL cnt txn=%0d got stall=%0d flush=%0d want stall=%0d flush=%0d",
                   txn, stall_cycles_o, flush_count_o, e.sc, e.fc);
        end
        $display("txn %0d ctl=%b stall=%0d flush=%0d", txn, act, stall_cycles_o, flush_count_o);
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1; mem_busy_i = 0; redirect_i = 0; ex_mem_read_i = 0;
    ex_rt_i = 0; id_rs_i = 0; id_rt_i = 0; id_uses_rt_i = 0;
    @(posedge clk);
    cyc(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // Load-use on rs
    cyc(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0);
    idle(3);
    // No false hazards
    cyc(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
    cyc(0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 0);
    cyc(0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 1);
    idle(2);
    // Redirect pulse -> F flush cycles
    cyc(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(4);
    // Freeze in the middle of a stall
    cyc(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 5'd8, 5'd8, 5'd0, 0);
    idle(3);
    // Redirect beats load-use in the same cycle
    cyc(0, 0, 1, 1, 5'd8, 5'd8, 5'd0, 0);
    idle(1);
    // Redirect while flushing reloads the flush budget
    cyc(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(3);
    // Reset during a flush
    cyc(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(2);
    // Drive the stall counter to saturation, then stall again
    for (int i = 0; i < CMAX + 5; i++) cyc(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc(0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0);
    idle(2);
    cyc(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // Randomized traffic with a small register set to provoke matches
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 63) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
